// File: rtl/speed_pkg.sv
// Shared types for the speed step controller: FSM state encoding and step direction constants.
package speed_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_STEP = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Raw active-low key -> 2-FF synchroniser -> active-high level accepted after DEBOUNCE_CYCLES stable cycles.
// Latency: 2 + DEBOUNCE_CYCLES cycles from raw edge to key_p; any glitch restarts the count.
module key_debouncer
    import speed_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
)(
    input  logic CLK,
    input  logic RSTn,
    input  logic key_raw,
    output logic key_p
);

    localparam int CNT_W = imax($clog2(DEBOUNCE_CYCLES), 1);

    logic [1:0]       sync;
    logic             pressed;
    logic [CNT_W-1:0] cnt;

    // Reset to "released" (raw high) so no phantom press appears after reset.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], key_raw};
        end
    end

    assign pressed = ~sync[1];

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cnt   <= '0;
            key_p <= 1'b0;
        end else if (pressed == key_p) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            key_p <= pressed;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/speed_step_ctrl.sv
// Debounced Key1/Key2 -> single-cycle ENABLE/UP_DOWN steps for contador, with a clamped shadow LEVEL.
// Raw press to ENABLE is 2 + DEBOUNCE_CYCLES + 1 cycles; AUTO_REPEAT_EN adds hold-to-repeat stepping.
module speed_step_ctrl
    import speed_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LEVEL_W         = 4,
    parameter int LEVEL_MIN       = 0,
    parameter int LEVEL_MAX       = 9,
    parameter int LEVEL_RST       = 0
`ifdef AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
`endif
)(
    input  logic               CLK,
    input  logic               RSTn,
    input  logic               Key1,
    input  logic               Key2,
    output logic               ENABLE,
    output logic               UP_DOWN,
    output logic [LEVEL_W-1:0] LEVEL,
    output logic               AT_MIN,
    output logic               AT_MAX
);

    logic   p1;
    logic   p2;
    state_t state;
    state_t state_nxt;
    logic   dir_nxt;
    logic   one_key;
    logic   key_dir;
    logic   key_legal;

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key1 (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .key_raw (Key1),
        .key_p   (p1)
    );

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key2 (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .key_raw (Key2),
        .key_p   (p2)
    );

    assign AT_MIN    = (LEVEL == LEVEL_W'(LEVEL_MIN));
    assign AT_MAX    = (LEVEL == LEVEL_W'(LEVEL_MAX));
    assign one_key   = p1 ^ p2;
    assign key_dir   = p1 ? DIR_DOWN : DIR_UP;
    assign key_legal = (key_dir == DIR_DOWN) ? !AT_MIN : !AT_MAX;

`ifdef AUTO_REPEAT_EN
    localparam int RPT_MAX = imax(REPEAT_DELAY, REPEAT_PERIOD);
    localparam int RPT_W   = imax($clog2(RPT_MAX), 1);

    logic             hold_vld;
    logic             hold_dir;
    logic             rpt_rep;
    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_run;
    logic             rpt_fire;
    logic             rpt_legal;

    // Only the key that opened this hold, held alone, advances the timer.
    // The step cycle itself counts towards the gap, hence the -2 (thresholds >= 2).
    assign rpt_run   = (state == S_HOLD) && hold_vld && one_key && (key_dir == hold_dir);
    assign rpt_fire  = rpt_run && (rpt_cnt == (rpt_rep ? RPT_W'(REPEAT_PERIOD - 2)
                                                       : RPT_W'(REPEAT_DELAY - 2)));
    assign rpt_legal = (hold_dir == DIR_DOWN) ? !AT_MIN : !AT_MAX;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            hold_vld <= 1'b0;
            hold_dir <= DIR_UP;
            rpt_rep  <= 1'b0;
            rpt_cnt  <= '0;
        end else begin
            if (state == S_IDLE) begin
                hold_vld <= one_key;
                hold_dir <= key_dir;
                rpt_rep  <= 1'b0;
            end else if (p1 && p2) begin
                rpt_rep <= 1'b0;
            end else if (rpt_fire && rpt_legal) begin
                rpt_rep <= 1'b1;
            end

            if (!rpt_run || rpt_fire) begin
                rpt_cnt <= '0;
            end else begin
                rpt_cnt <= rpt_cnt + 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        dir_nxt   = UP_DOWN;
        case (state)
            S_IDLE: begin
                if (p1 && p2) begin
                    state_nxt = S_HOLD;
                end else if (one_key) begin
                    if (key_legal) begin
                        state_nxt = S_STEP;
                        dir_nxt   = key_dir;
                    end else begin
                        state_nxt = S_HOLD;
                    end
                end
            end
            S_STEP: begin
                state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (!p1 && !p2) begin
                    state_nxt = S_IDLE;
                end
`ifdef AUTO_REPEAT_EN
                else if (rpt_fire && rpt_legal) begin
                    state_nxt = S_STEP;
                    dir_nxt   = hold_dir;
                end
`endif
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // LEVEL moves on the edge that closes S_STEP, the same edge contador counts.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state   <= S_IDLE;
            ENABLE  <= 1'b0;
            UP_DOWN <= DIR_UP;
            LEVEL   <= LEVEL_W'(LEVEL_RST);
        end else begin
            state   <= state_nxt;
            ENABLE  <= (state_nxt == S_STEP);
            UP_DOWN <= dir_nxt;
            if (state == S_STEP) begin
                LEVEL <= (UP_DOWN == DIR_DOWN) ? LEVEL - 1'b1 : LEVEL + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_speed_step_ctrl.sv
// Randomised and directed bench for speed_step_ctrl against a key/step reference model (AUTO_REPEAT_EN aware).
module tb_speed_step_ctrl;

    localparam int DB   = 4;
    localparam int LMIN = 0;
    localparam int LMAX = 9;
`ifdef AUTO_REPEAT_EN
    localparam int RDLY = 20;
    localparam int RPER = 8;
`endif

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic       Key1 = 1'b1;
    logic       Key2 = 1'b1;
    logic       ENABLE;
    logic       UP_DOWN;
    logic [3:0] LEVEL;
    logic       AT_MIN;
    logic       AT_MAX;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int pulse_at[$];

    speed_step_ctrl #(
        .DEBOUNCE_CYCLES (DB),
        .LEVEL_W         (4),
        .LEVEL_MIN       (LMIN),
        .LEVEL_MAX       (LMAX),
        .LEVEL_RST       (0)
`ifdef AUTO_REPEAT_EN
        ,
        .REPEAT_DELAY    (RDLY),
        .REPEAT_PERIOD   (RPER)
`endif
    ) dut (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .Key1    (Key1),
        .Key2    (Key2),
        .ENABLE  (ENABLE),
        .UP_DOWN (UP_DOWN),
        .LEVEL   (LEVEL),
        .AT_MIN  (AT_MIN),
        .AT_MAX  (AT_MAX)
    );

    always #5 CLK = ~CLK;

    // Reference model: key 0 = Key1 (down), key 1 = Key2 (up)
    bit m_sa[2];
    bit m_sb[2];
    bit m_p[2];
    int m_run[2];
    bit m_busy;
    bit m_en;
    bit m_dir;
    int m_lvl;
    int m_hkey;
    int m_rrun;
    bit m_rep;

    function automatic bit legal(input int k, input int lvl);
        return (k == 1) ? (lvl > LMIN) : (lvl < LMAX);
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < 2; i++) begin
            m_sa[i] = 1'b0; m_sb[i] = 1'b0; m_p[i] = 1'b0; m_run[i] = 0;
        end
        m_busy = 0; m_en = 0; m_dir = 0; m_lvl = 0;
        m_hkey = -1; m_rrun = 0; m_rep = 0;
    endtask

    task automatic mdl_step(input bit n1, input bit n2);
        bit p1, p2, was_en;
        int k;
        p1 = m_p[0];
        p2 = m_p[1];
        was_en = m_en;
        if (was_en) m_lvl += m_dir ? -1 : 1;
        m_en = 0;
        if (!m_busy) begin
            if (p1 || p2) begin
                m_busy = 1; m_rrun = 0; m_rep = 0;
                if (p1 && p2) begin
                    m_hkey = -1;
                end else begin
                    k = p1 ? 1 : 0;
                    m_hkey = k;
                    if (legal(k, m_lvl)) begin m_en = 1; m_dir = k[0]; end
                end
            end
        end else if (!was_en) begin
            if (!p1 && !p2) begin
                m_busy = 0;
            end
`ifdef AUTO_REPEAT_EN
            else if (p1 != p2 && m_hkey == (p1 ? 1 : 0)) begin
                m_rrun++;
                if (m_rrun == (m_rep ? RPER : RDLY) - 1) begin
                    m_rrun = 0;
                    if (legal(m_hkey, m_lvl)) begin
                        m_en = 1; m_dir = m_hkey[0]; m_rep = 1;
                    end
                end
            end else begin
                m_rrun = 0;
                if (p1 && p2) m_rep = 0;
            end
`endif
        end
        for (int i = 0; i < 2; i++) begin
            if (m_sb[i] != m_p[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin m_p[i] = m_sb[i]; m_run[i] = 0; end
            end else begin
                m_run[i] = 0;
            end
            m_sb[i] = m_sa[i];
            m_sa[i] = (i == 0) ? n1 : n2;
        end
    endtask

    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) mdl_reset();
        else       mdl_step(!Key1, !Key2);
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        cyc++;
        chk("enable",  int'(ENABLE),  int'(m_en));
        chk("up_down", int'(UP_DOWN), int'(m_dir));
        chk("level",   int'(LEVEL),   m_lvl);
        chk("at_min",  int'(AT_MIN),  int'(m_lvl == LMIN));
        chk("at_max",  int'(AT_MAX),  int'(m_lvl == LMAX));
        if (ENABLE) pulse_at.push_back(cyc);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(input logic k1, input logic k2, input int hold, input int rel);
        Key1 = k1; Key2 = k2;
        ticks(hold);
        Key1 = 1'b1; Key2 = 1'b1;
        ticks(rel);
    endtask

    task automatic do_reset();
        RSTn = 1'b0;
        ticks(2);
        RSTn = 1'b1;
        ticks(2);
    endtask

    task automatic clr();
        pulse_at.delete();
        cyc = 0;
    endtask

    function automatic int first_pulse();
        return (pulse_at.size() > 0) ? pulse_at[0] : -1;
    endfunction

    initial begin
        int got;
        int exp_at[$];
        // Reset state
        ticks(2);
        chk("rst_enable", int'(ENABLE), 0);
        chk("rst_level",  int'(LEVEL),  0);
        chk("rst_at_min", int'(AT_MIN), 1);
        RSTn = 1'b1;
        ticks(3);

        // 1: single press, exact latency
        clr();
        press(1'b1, 1'b0, 10, 15);
        chk("t1_pulses", pulse_at.size(), 1);
        chk("t1_cycle", first_pulse(), 2 + DB + 1);
        chk("t1_level", int'(LEVEL), 1);
        chk("t1_dir", int'(UP_DOWN), 0);

        // 2: bounce then stable low
        clr();
        foreach (exp_at[i]) exp_at.delete(i);
        Key2 = 1'b0; tick(); Key2 = 1'b1; tick(); Key2 = 1'b0; ticks(2);
        Key2 = 1'b1; tick(); Key2 = 1'b0; tick();
        chk("t2_no_bounce_pulse", pulse_at.size(), 0);
        ticks(12);
        Key2 = 1'b1;
        ticks(15);
        chk("t2_pulses", pulse_at.size(), 1);
        chk("t2_level", int'(LEVEL), 2);

        // 3: limits
        do_reset();
        clr();
        press(1'b0, 1'b1, 12, 12);
        chk("t3_min_pulses", pulse_at.size(), 0);
        chk("t3_at_min", int'(AT_MIN), 1);
        for (int i = 0; i < 9; i++) press(1'b1, 1'b0, 10, 12);
        chk("t3_level9", int'(LEVEL), 9);
        chk("t3_at_max", int'(AT_MAX), 1);
        clr();
        press(1'b1, 1'b0, 10, 12);
        chk("t3_max_pulses", pulse_at.size(), 0);
        chk("t3_level_hold", int'(LEVEL), 9);

        // 4: both keys together, then down from 3
        clr();
        press(1'b0, 1'b0, 10, 12);
        chk("t4_both_pulses", pulse_at.size(), 0);
        for (int i = 0; i < 6; i++) press(1'b0, 1'b1, 10, 12);
        chk("t4_level3", int'(LEVEL), 3);
        clr();
        press(1'b0, 1'b1, 10, 12);
        chk("t4_pulses", pulse_at.size(), 1);
        chk("t4_dir", int'(UP_DOWN), 1);
        chk("t4_level", int'(LEVEL), 2);

        // 5: reset right after a step with key held
        Key2 = 1'b0;
        got = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (ENABLE) begin got = 1; break; end
        end
        chk("t5_step_seen", got, 1);
        tick();
        RSTn = 1'b0;
        #1;
        chk("t5_rst_enable", int'(ENABLE), 0);
        chk("t5_rst_level", int'(LEVEL), 0);
        ticks(3);
        RSTn = 1'b1;
        clr();
        ticks(15);
        chk("t5_pulses", pulse_at.size(), 1);
        chk("t5_level", int'(LEVEL), 1);
        Key2 = 1'b1;
        ticks(12);

`ifdef AUTO_REPEAT_EN
        // 6: hold-to-repeat
        do_reset();
        clr();
        Key2 = 1'b0;
        ticks(60);
        Key2 = 1'b1;
        exp_at = '{7, 27, 35, 43, 51, 59};
        chk("t6_pulses", pulse_at.size(), exp_at.size());
        for (int i = 0; i < exp_at.size(); i++) begin
            if (i < pulse_at.size()) chk("t6_pulse_cycle", pulse_at[i], exp_at[i]);
        end
        chk("t6_level", int'(LEVEL), 6);
        ticks(12);
`endif

        // Random key activity, checked every cycle against the model
        for (int s = 0; s < 160; s++) begin
            if ($urandom_range(0, 39) == 0) begin
                RSTn = 1'b0;
                ticks(2);
                RSTn = 1'b1;
            end
            Key1 = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
            Key2 = ($urandom_range(0, 1) == 0) ? 1'b0 : 1'b1;
            ticks($urandom_range(1, 45));
        end
        Key1 = 1'b1; Key2 = 1'b1;
        ticks(20);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
